// File: rtl/dbg_ctrl.sv
// Debug controller: turns host HALT/RESUME/STEP/ACCESS commands into
// processor debug-interface requests and returns a one-cycle response.
// Every output is registered.
// Optional wait-state timeout is built when DBG_CTRL_TIMEOUT_EN is defined.
module dbg_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_cmd,
  input  logic        host_write,
  input  logic [6:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [2:0]  dbg_status,
  output logic        enter_debug,
  output logic        req_halt,
  output logic        req_resume,
  output logic        step,
  output logic        dm_write,
  output logic [6:0]  dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        halted,
  input  logic        running,
  input  logic        stalled,
  input  logic        dm_access_valid,
  input  logic [31:0] dm_rdata
);

  localparam logic [1:0] CMD_HALT   = 2'd0;
  localparam logic [1:0] CMD_RESUME = 2'd1;
  localparam logic [1:0] CMD_STEP   = 2'd2;
  localparam logic [1:0] CMD_ACCESS = 2'd3;

  typedef enum logic [2:0] {
    IDLE, HALT_WAIT, RESUME_WAIT, STEP_GO, STEP_WAIT, ACCESS_WAIT, RESP
  } state_e;

  state_e      state_q, state_d;
  logic        host_ready_q, host_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [2:0]  dbg_status_q, dbg_status_d;
  logic        enter_debug_q, enter_debug_d;
  logic        req_halt_q, req_halt_d;
  logic        req_resume_q, req_resume_d;
  logic        step_q, step_d;
  logic        dm_write_q, dm_write_d;
  logic [6:0]  dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        seen_run_q, seen_run_d;
  logic        tmo_hit_c;

`ifdef DBG_CTRL_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        in_wait_c;

  assign in_wait_c = (state_q == HALT_WAIT) || (state_q == RESUME_WAIT) ||
                     (state_q == STEP_WAIT) || (state_q == ACCESS_WAIT);
  assign tmo_hit_c = in_wait_c && (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 32'd1));

  // Counter runs while staying in a wait state; any transition clears it
  always_comb begin
    tmo_cnt_d = '0;
    if (in_wait_c && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo_hit_c  = 1'b0;
`endif

  // Next-state and next-output logic; requests default low every cycle
  always_comb begin
    state_d       = state_q;
    enter_debug_d = 1'b0;
    req_halt_d    = 1'b0;
    req_resume_d  = 1'b0;
    step_d        = 1'b0;
    dm_write_d    = 1'b0;
    dm_addr_d     = dm_addr_q;
    dm_wdata_d    = dm_wdata_q;
    write_d       = write_q;
    err_d         = err_q;
    seen_run_d    = seen_run_q;
    resp_rdata_d  = resp_rdata_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    dbg_status_d  = {stalled, running, halted};

    case (state_q)
      IDLE: begin
        if (host_valid && host_ready_q) begin
          err_d        = 1'b0;
          seen_run_d   = 1'b0;
          resp_rdata_d = '0;
          case (host_cmd)
            CMD_HALT: begin
              if (halted) begin
                state_d = RESP;
              end else begin
                state_d       = HALT_WAIT;
                enter_debug_d = 1'b1;
                req_halt_d    = 1'b1;
              end
            end
            CMD_RESUME: begin
              if (!halted) begin
                state_d = RESP;
                err_d   = 1'b1;
              end else begin
                state_d      = RESUME_WAIT;
                req_resume_d = 1'b1;
              end
            end
            CMD_STEP: begin
              if (!halted) begin
                state_d = RESP;
                err_d   = 1'b1;
              end else begin
                state_d      = STEP_GO;
                step_d       = 1'b1;
                req_resume_d = 1'b1;
              end
            end
            CMD_ACCESS: begin
              if (!halted) begin
                state_d = RESP;
                err_d   = 1'b1;
              end else begin
                state_d    = ACCESS_WAIT;
                dm_addr_d  = host_addr;
                dm_wdata_d = host_wdata;
                write_d    = host_write;
                dm_write_d = host_write;
              end
            end
          endcase
        end
      end
      HALT_WAIT: begin
        if (halted) begin
          state_d = RESP;
        end else if (tmo_hit_c) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          req_halt_d = 1'b1;
        end
      end
      RESUME_WAIT: begin
        if (running && !halted) begin
          state_d = RESP;
        end else if (tmo_hit_c) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          req_resume_d = 1'b1;
        end
      end
      STEP_GO: begin
        state_d = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (running) seen_run_d = 1'b1;
        // A halted seen before the core ever ran is the pre-step halt, not completion
        if (halted && (seen_run_q || running)) begin
          state_d = RESP;
        end else if (tmo_hit_c) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      ACCESS_WAIT: begin
        if (dm_access_valid) begin
          state_d      = RESP;
          resp_rdata_d = write_q ? 32'd0 : dm_rdata;
        end else if (tmo_hit_c) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          dm_write_d = write_q;
        end
      end
      RESP: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
      end
      default: state_d = IDLE;
    endcase

    host_ready_d = (state_d == IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      host_ready_q  <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= '0;
      dbg_status_q  <= '0;
      enter_debug_q <= 1'b0;
      req_halt_q    <= 1'b0;
      req_resume_q  <= 1'b0;
      step_q        <= 1'b0;
      dm_write_q    <= 1'b0;
      dm_addr_q     <= '0;
      dm_wdata_q    <= '0;
      write_q       <= 1'b0;
      err_q         <= 1'b0;
      seen_run_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      host_ready_q  <= host_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      dbg_status_q  <= dbg_status_d;
      enter_debug_q <= enter_debug_d;
      req_halt_q    <= req_halt_d;
      req_resume_q  <= req_resume_d;
      step_q        <= step_d;
      dm_write_q    <= dm_write_d;
      dm_addr_q     <= dm_addr_d;
      dm_wdata_q    <= dm_wdata_d;
      write_q       <= write_d;
      err_q         <= err_d;
      seen_run_q    <= seen_run_d;
    end
  end

  assign host_ready  = host_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign dbg_status  = dbg_status_q;
  assign enter_debug = enter_debug_q;
  assign req_halt    = req_halt_q;
  assign req_resume  = req_resume_q;
  assign step        = step_q;
  assign dm_write    = dm_write_q;
  assign dm_addr     = dm_addr_q;
  assign dm_wdata    = dm_wdata_q;

endmodule
